// File: rtl/mic_decimator_if.sv
// rtl/mic_decimator_if.sv - sample-in / averaged-out bundle for mic_decimator (clip member present with CLIP_DETECT_EN)
interface mic_decimator_if #(
    parameter int D_WIDTH = 8
);
    logic               en;
    logic [2:0]         ratio_log2;
    logic               sample_valid;
    logic [D_WIDTH-1:0] sample_in;
    logic [D_WIDTH-1:0] mic_signal;
    logic               wr;
    logic               rd;
`ifdef CLIP_DETECT_EN
    logic               clip;

    modport master (
        output en, ratio_log2, sample_valid, sample_in,
        input  mic_signal, wr, rd, clip
    );

    modport slave (
        input  en, ratio_log2, sample_valid, sample_in,
        output mic_signal, wr, rd, clip
    );
`else
    modport master (
        output en, ratio_log2, sample_valid, sample_in,
        input  mic_signal, wr, rd
    );

    modport slave (
        input  en, ratio_log2, sample_valid, sample_in,
        output mic_signal, wr, rd
    );
`endif
endinterface

// File: rtl/mic_decimator.sv
// rtl/mic_decimator.sv - block-average decimator feeding the delay line; optional sticky clip flag via CLIP_DETECT_EN
module mic_decimator #(
    parameter int D_WIDTH  = 8,
    parameter int LOG2_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    mic_decimator_if.slave bus
);
    localparam int ACC_W = D_WIDTH + LOG2_MAX;
    localparam int NW    = $clog2(LOG2_MAX + 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q;
    logic [LOG2_MAX-1:0]  cnt_q;
    logic [NW-1:0]        n_lat_q;
    logic [D_WIDTH-1:0]   mic_q;
    logic                 wr_q;

    logic [NW-1:0]        ratio_clamped;
    logic [NW-1:0]        n_eff;
    logic [LOG2_MAX:0]    last_idx;
    logic [ACC_W-1:0]     sum;
    logic                 accept;
    logic                 last_smp;

    always_comb begin
        state_d       = state_q;
        ratio_clamped = NW'(bus.ratio_log2);
        if (int'(bus.ratio_log2) > LOG2_MAX) begin
            ratio_clamped = NW'(LOG2_MAX);
        end

        case (state_q)
            IDLE:    if (bus.en)  state_d = ACCUM;
            ACCUM:   if (!bus.en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The block size is taken from ratio_log2 only on a block's first sample.
        n_eff    = (state_q == IDLE || cnt_q == '0) ? ratio_clamped : n_lat_q;
        last_idx = ((LOG2_MAX + 1)'(1) << n_eff) - (LOG2_MAX + 1)'(1);
        accept   = bus.en && bus.sample_valid;
        last_smp = accept && ({1'b0, cnt_q} == last_idx);
        sum      = acc_q + ACC_W'(bus.sample_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            n_lat_q <= '0;
            mic_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= last_smp;
            if (!bus.en) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                if (cnt_q == '0) begin
                    n_lat_q <= ratio_clamped;
                end
                if (last_smp) begin
                    mic_q <= D_WIDTH'(sum >> n_eff);
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.mic_signal = mic_q;
    assign bus.wr         = wr_q;
    assign bus.rd         = wr_q;

`ifdef CLIP_DETECT_EN
    logic clip_q;

    // Sticky until reset; en deliberately does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_q <= 1'b0;
        end else if (accept && (bus.sample_in == '0 || bus.sample_in == '1)) begin
            clip_q <= 1'b1;
        end
    end

    assign bus.clip = clip_q;
`endif
endmodule

// File: doc/mic_decimator.md
# mic_decimator

Upstream front-end for the delay stage. Accepts raw unsigned microphone samples at the ADC rate, averages blocks of 2^ratio_log2 consecutive samples, and presents one averaged sample per block on mic_signal. A single-cycle write strobe tells the delay buffer when to store it. Two states: IDLE and ACCUM. The output feeds mic_signal/wr/rd of the delay-line block directly.

## Interface
- D_WIDTH, 8: sample width in bits, unsigned; input and output.
- LOG2_MAX, 4: maximum decimation exponent; the largest block is 2^LOG2_MAX samples.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  enable; low forces IDLE and discards any partial block.
- ratio_log2  in  3  decimation exponent N; block size is 2^N. Values above LOG2_MAX are clamped to LOG2_MAX.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_in  in  D_WIDTH  raw microphone sample.
- mic_signal  out  D_WIDTH  last averaged sample; held between strobes.
- wr  out  1  one-cycle pulse; mic_signal has been updated this cycle.
- rd  out  1  identical to wr; lets the delay RAM read in lockstep.
- clip  out  1  sticky clip flag; present only with CLIP_DETECT_EN.

## Operation
- Accumulator acc is D_WIDTH+LOG2_MAX bits, unsigned, and cannot overflow. Sample counter cnt is LOG2_MAX bits.
- IDLE:
  - acc=0, cnt=0.
  - Go to ACCUM when en=1. The first sample may be accepted in the same cycle that en is seen high.
- ACCUM, on each cycle with en=1 and sample_valid=1:
  - If cnt==0, latch the clamped ratio_log2 into n_lat. Changing ratio_log2 mid-block has no effect until the next block.
  - If cnt < 2^n_lat-1: acc += sample_in; cnt += 1.
  - If cnt == 2^n_lat-1 (final sample):
    - mic_signal <= (acc+sample_in) >> n_lat. This truncates; no rounding.
    - Assert wr=rd=1 for one cycle.
    - acc <= 0, cnt <= 0.
- ACCUM with sample_valid=0: hold acc and cnt; wr=0.
- n_lat=0 is pass-through: every valid sample goes to mic_signal with a strobe.
- en deasserted in any state:
  - Go to IDLE next edge; clear acc and cnt.
  - The partial block is discarded and produces no strobe.
  - mic_signal keeps its last value.
- Back-to-back blocks are supported. With sample_valid held high, a new block starts on the cycle after the final sample, with no dead cycle.

## Timing
- Reset values: mic_signal=0, wr=0, rd=0, clip=0, state=IDLE, acc=0, cnt=0, n_lat=0.
- Latency: mic_signal and wr/rd change on the clock edge that accepts the final sample of a block. They are visible during the following cycle.
- wr and rd are never high on two consecutive cycles unless n_lat=0 and sample_valid is continuous.
- Strobe spacing is at least 2^n_lat cycles.
- en falling in the same cycle as a final sample: en wins. No strobe is issued and the block is discarded.
- rst mid-block: all state returns to reset values immediately (asynchronous). No strobe is issued.

## Configuration
- CLIP_DETECT_EN defined:
  - The clip port exists.
  - clip is set on the edge after any accepted sample_in equal to 0 or 2^D_WIDTH-1.
  - It stays high until rst; en has no effect on it.
- CLIP_DETECT_EN undefined:
  - The clip port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: assert rst mid-stream -> mic_signal=0, wr=rd=0 immediately; clip=0 if compiled in.
- Pass-through: ratio_log2=0, valid samples 10,20,30 on consecutive cycles -> mic_signal shows 10,20,30 one cycle after each, and wr pulses on three consecutive cycles.
- Average: ratio_log2=2, samples 4,8,12,17 -> one wr pulse after the 4th sample with mic_signal=10 (41>>2). No pulse after samples 1 to 3.
- Clamp and latch:
  - ratio_log2=7 -> 16-sample blocks; 16×255 gives mic_signal=255.
  - ratio_log2 changed from 1 to 2 after the first sample of a block -> that block ends after 2 samples; the next block is 4 samples.
- Abort: ratio_log2=3, 5 valid samples, then en=0 for one cycle, then en=1 and 8 samples of 100 -> exactly one wr pulse, mic_signal=100.
- Gaps and clip (CLIP_DETECT_EN defined): ratio_log2=1, samples 255, idle 3 cycles, 1 -> mic_signal=128 one cycle after the sample 1. clip rises after the 255 and stays high until rst.
